// File: rtl/sig_acq_pkg.sv
// Shared constants and entry layout for the signal-acquisition timestamp path.
// Entries are {type, epoch, timer count}, 48 bits wide.
package sig_acq_pkg;

  localparam int unsigned TS_W         = 48;
  localparam int unsigned EPOCH_W      = 15;
  localparam int unsigned CNT_W        = 32;
  localparam logic        TYPE_TRIG    = 1'b0;
  localparam logic        TYPE_HB      = 1'b1;
  localparam int unsigned TS_TYPE_BIT  = 47;
  localparam int unsigned TS_EPOCH_LSB = 32;

  typedef struct packed {
    logic               kind;
    logic [EPOCH_W-1:0] epoch;
    logic [CNT_W-1:0]   count;
  } ts_entry_t;

  // Pack one entry using the documented field offsets
  function automatic ts_entry_t make_entry(input logic kind,
                                           input logic [EPOCH_W-1:0] epoch,
                                           input logic [CNT_W-1:0] count);
    logic [TS_W-1:0] v;
    v                              = '0;
    v[TS_TYPE_BIT]                 = kind;
    v[TS_EPOCH_LSB +: EPOCH_W]     = epoch;
    v[TS_EPOCH_LSB-1:0]            = count;
    return ts_entry_t'(v);
  endfunction

endpackage

// File: rtl/ts_fifo.sv
// Single-clock synchronous FIFO with registered status and a registered read port.
// A write while full is refused here; the caller does the drop accounting.
module ts_fifo #(
  parameter int unsigned W     = 48,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level
);

  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok_c;
  logic          rd_ok_c;
  logic [AW:0]   level_next_c;

  // Both decisions use the registered flags, so a same-cycle read never frees room for a write
  always_comb begin
    wr_ok_c      = wr_en & ~full & ~clr;
    rd_ok_c      = rd_en & ~empty & ~clr;
    level_next_c = level + LW'(wr_ok_c) - LW'(rd_ok_c);
  end

  always_ff @(posedge clk) begin
    if (wr_ok_c) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_ok_c) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok_c) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      rd_valid <= rd_ok_c;
      level    <= level_next_c;
      empty    <= (level_next_c == LW'(0));
      full     <= (level_next_c == LW'(DEPTH));
    end
  end

endmodule

// File: rtl/timestamp_capture.sv
// Turns synchronized trigger edges and idle heartbeats into 48-bit timestamps
// {type, epoch, count} and queues them for host readout.
module timestamp_capture #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AW       = 4,
  parameter int unsigned HB_TICKS = 100,
  parameter int unsigned EPOCH_W  = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        ena,
  input  logic                        trig,
  input  logic [31:0]                 count,
  input  logic                        pulse_full,
  input  logic                        pulse_10ms,
  input  logic                        rd_en,
  output logic [sig_acq_pkg::TS_W-1:0] rd_data,
  output logic                        rd_valid,
  output logic                        empty,
  output logic                        full,
  output logic [AW:0]                 level,
  output logic                        overflow,
  output logic [7:0]                  drop_cnt
);

  import sig_acq_pkg::*;

  localparam int unsigned IDLE_W = (HB_TICKS > 1) ? $clog2(HB_TICKS) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(HB_TICKS - 1);
  localparam logic HB_ON = (HB_TICKS != 0);

  logic               s1;
  logic               s2;
  logic               s3;
  logic [EPOCH_W-1:0] epoch;
  logic [IDLE_W-1:0]  idle;
  logic               rise_c;
  logic               tick_c;
  logic               hb_c;
  logic               wr_en_c;
  logic               drop_c;
  logic [EPOCH_W-1:0] epoch_now_c;
  ts_entry_t          wr_data_c;

  // Trigger synchronizer keeps running through clr and ena=0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= trig;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Count has already wrapped when pulse_full is high, so the stored epoch must include it
  always_comb begin
    epoch_now_c = epoch + EPOCH_W'(pulse_full);
    rise_c      = s2 & ~s3 & ena;
    tick_c      = pulse_10ms & ena & HB_ON;
    hb_c        = tick_c & (idle == IDLE_LAST);
    wr_en_c     = ~clr & (rise_c | hb_c);
    drop_c      = wr_en_c & full;
    wr_data_c   = make_entry(rise_c ? TYPE_TRIG : TYPE_HB, epoch_now_c, count);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      epoch    <= '0;
      idle     <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr) begin
      epoch    <= '0;
      idle     <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      epoch <= epoch_now_c;
      if (rise_c || hb_c) idle <= '0;
      else if (tick_c)    idle <= idle + IDLE_W'(1);
      if (drop_c) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  ts_fifo #(
    .W     (TS_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .wr_en    (wr_en_c),
    .wr_data  (wr_data_c),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .empty    (empty),
    .full     (full),
    .level    (level)
  );

endmodule

// File: tb/tb_timestamp_capture.sv
// Directed bench for timestamp_capture: capture latency, wrap epoch, heartbeat,
// overflow accounting, clr, gating and asynchronous reset.
module tb_timestamp_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        ena;
  logic        trig;
  logic [31:0] count;
  logic        pulse_full;
  logic        pulse_10ms;
  logic        rd_en;
  logic [47:0] rd_data;
  logic        rd_valid;
  logic        empty;
  logic        full;
  logic [4:0]  level;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] ecnt;

  always #5 clk = ~clk;

  timestamp_capture #(
    .DEPTH    (16),
    .AW       (4),
    .HB_TICKS (3),
    .EPOCH_W  (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .ena        (ena),
    .trig       (trig),
    .count      (count),
    .pulse_full (pulse_full),
    .pulse_10ms (pulse_10ms),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .empty      (empty),
    .full       (full),
    .level      (level),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] ent(input logic k, input logic [14:0] ep, input logic [31:0] c);
    return {k, ep, c};
  endfunction

  // One clock: single-cycle strobes drop, timer advances, wrap pulse follows count==0
  task automatic step();
    @(posedge clk);
    #1;
    trig       = 1'b0;
    pulse_10ms = 1'b0;
    rd_en      = 1'b0;
    count      = count + 32'd1;
    pulse_full = (count == 32'd0);
  endtask

  // trig seen by s1 at the next edge while count=c; entry holds c+2
  task automatic fire(input logic [31:0] c);
    count      = c;
    pulse_full = 1'b0;
    trig       = 1'b1;
    repeat (4) step();
  endtask

  task automatic rd_chk(input string tag, input logic [47:0] exp);
    rd_en = 1'b1;
    step();
    chk({tag, " valid"}, 64'(rd_valid), 64'd1);
    chk({tag, " data"}, 64'(rd_data), 64'(exp));
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; ena = 1'b0; trig = 1'b0;
    pulse_full = 1'b0; pulse_10ms = 1'b0; rd_en = 1'b0; count = 32'd0;
    repeat (5) step();
    chk("rst empty",    64'(empty),    64'd1);
    chk("rst full",     64'(full),     64'd0);
    chk("rst level",    64'(level),    64'd0);
    chk("rst rd_valid", 64'(rd_valid), 64'd0);
    chk("rst overflow", 64'(overflow), 64'd0);
    chk("rst drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst rd_data",  64'(rd_data),  64'd0);

    rst = 1'b1; ena = 1'b1;
    repeat (3) step();
    chk("idle empty",    64'(empty),    64'd1);
    chk("idle level",    64'(level),    64'd0);
    chk("idle rd_valid", 64'(rd_valid), 64'd0);
    chk("idle overflow", 64'(overflow), 64'd0);

    // single capture
    fire(32'h100);
    chk("single level", 64'(level), 64'd1);
    chk("single empty", 64'(empty), 64'd0);
    rd_chk("single", ent(1'b0, 15'd0, 32'h102));
    step();
    chk("single valid drop", 64'(rd_valid), 64'd0);
    chk("single empty after", 64'(empty), 64'd1);
    chk("single data hold", 64'(rd_data), 64'(ent(1'b0, 15'd0, 32'h102)));

    // capture in the wrap cycle carries the new epoch
    fire(32'hFFFF_FFFE);
    rd_chk("wrap", ent(1'b0, 15'd1, 32'h0));
    fire(32'h200);
    rd_chk("post wrap", ent(1'b0, 15'd1, 32'h202));

    // heartbeat after three idle ticks
    pulse_10ms = 1'b1; step();
    pulse_10ms = 1'b1; step();
    step();
    chk("hb two ticks", 64'(level), 64'd0);
    pulse_10ms = 1'b1; ecnt = count; step();
    step();
    chk("hb one entry", 64'(level), 64'd1);
    rd_chk("hb", ent(1'b1, 15'd1, ecnt));
    step();
    chk("hb drained", 64'(empty), 64'd1);

    // rise and third tick in the same cycle: trigger only
    pulse_10ms = 1'b1; step();
    pulse_10ms = 1'b1; step();
    count = 32'h300; trig = 1'b1; step();
    step();
    pulse_10ms = 1'b1; step();
    step();
    chk("collide level", 64'(level), 64'd1);
    rd_chk("collide", ent(1'b0, 15'd1, 32'h302));
    pulse_10ms = 1'b1; step();
    pulse_10ms = 1'b1; step();
    step();
    chk("idle cleared", 64'(level), 64'd0);

    // overflow: 20 rises into 16 slots
    for (int i = 0; i < 20; i++) begin
      trig = 1'b1; step();
      step();
    end
    repeat (3) step();
    chk("ovf full",     64'(full),     64'd1);
    chk("ovf level",    64'(level),    64'd16);
    chk("ovf overflow", 64'(overflow), 64'd1);
    chk("ovf drop_cnt", 64'(drop_cnt), 64'd4);

    // write while full with a same-cycle read still drops
    trig = 1'b1; step();
    step();
    rd_en = 1'b1; step();
    step();
    chk("full rw drop_cnt", 64'(drop_cnt), 64'd5);
    chk("full rw level",    64'(level),    64'd15);
    chk("full rw full",     64'(full),     64'd0);

    // clr flushes; a rise in the clr cycle is discarded
    trig = 1'b1; step();
    step();
    clr = 1'b1; step();
    clr = 1'b0; step();
    chk("clr level",    64'(level),    64'd0);
    chk("clr empty",    64'(empty),    64'd1);
    chk("clr full",     64'(full),     64'd0);
    chk("clr overflow", 64'(overflow), 64'd0);
    chk("clr drop_cnt", 64'(drop_cnt), 64'd0);
    chk("clr rd_valid", 64'(rd_valid), 64'd0);
    fire(32'h400);
    rd_chk("clr epoch", ent(1'b0, 15'd0, 32'h402));

    // ena=0: rises and ticks ignored
    ena = 1'b0;
    for (int i = 0; i < 200; i++) begin
      pulse_10ms = 1'b1;
      trig       = (i < 10) && (i % 2 == 0);
      step();
    end
    repeat (3) step();
    chk("gate level", 64'(level), 64'd0);
    chk("gate empty", 64'(empty), 64'd1);
    rd_en = 1'b1; step();
    chk("rd empty valid", 64'(rd_valid), 64'd0);
    chk("rd empty hold",  64'(rd_data),  64'(ent(1'b0, 15'd0, 32'h402)));

    // idle held at 0 while gated
    ena = 1'b1;
    pulse_10ms = 1'b1; step();
    pulse_10ms = 1'b1; step();
    step();
    chk("ungate two ticks", 64'(level), 64'd0);
    pulse_10ms = 1'b1; ecnt = count; step();
    step();
    rd_chk("ungate hb", ent(1'b1, 15'd0, ecnt));

    // asynchronous reset mid-operation
    fire(32'h500);
    fire(32'h600);
    rd_en = 1'b1; step();
    chk("pre rst valid", 64'(rd_valid), 64'd1);
    chk("pre rst level", 64'(level),    64'd1);
    #2 rst = 1'b0;
    #1;
    chk("async rst valid", 64'(rd_valid), 64'd0);
    chk("async rst level", 64'(level),    64'd0);
    chk("async rst empty", 64'(empty),    64'd1);
    rst = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timestamp_capture.md
Name: timestamp_capture

Overview:
- Sits directly downstream of the 32-bit free-running timer.
- Converts acquisition trigger edges into 48-bit timestamps: a 15-bit wrap epoch plus the timer's 32-bit count.
- Buffers timestamps in a small synchronous FIFO for the host-readout logic.
- Inserts periodic heartbeat entries from the timer's 10 ms tick, so the host can tell "no triggers" from "dead link".

Parameters:
- DEPTH, 16: FIFO entries; power of 2, range 4..256.
- AW, 4: log2(DEPTH).
- HB_TICKS, 100: number of 10 ms ticks without a trigger before a heartbeat entry is written; 0 disables heartbeats.
- EPOCH_W, 15: epoch counter width. Entry width is fixed at 1+EPOCH_W+32 = 48.

Ports:
- clk  in  1  system clock, same clock as the timer.
- rst  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush; assert together with the timer clr.
- ena  in  1  capture enable.
- trig  in  1  asynchronous trigger pin, active-high.
- count  in  32  timer count.
- pulse_full  in  1  timer wrap pulse.
- pulse_10ms  in  1  timer 10 ms tick.
- rd_en  in  1  read request.
- rd_data  out  48  entry layout: [47] type (0 = trigger, 1 = heartbeat), [46:32] epoch, [31:0] count.
- rd_valid  out  1  rd_data is valid this cycle.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- level  out  AW+1  number of stored entries.
- overflow  out  1  sticky: at least one entry dropped.
- drop_cnt  out  8  saturating count of dropped entries.

Behaviour:
- Reset (rst low, asynchronous):
  - Outputs: rd_data=0, rd_valid=0, empty=1, full=0, level=0, overflow=0, drop_cnt=0.
  - Internal state: synchronizer flops, epoch, idle counter and FIFO pointers all cleared.
- Trigger path:
  - 3-flop chain s1->s2->s3 on trig; rise = s2 & ~s3.
  - Trigger high first captured by s1 at edge k -> entry written at edge k+2. The count stored is the count input present during the cycle before edge k+2.
  - Fixed pin-to-capture offset is 2 clocks plus up to 1 clock of asynchronous uncertainty.
- Epoch:
  - Increments (wrapping at EPOCH_W) on every pulse_full, independent of ena.
  - pulse_full is asserted in the cycle in which count has already wrapped to 0. A capture in that same cycle therefore stores epoch+1 (stored epoch = epoch + pulse_full), never the stale epoch.
- Heartbeat:
  - The idle counter increments on pulse_10ms when ena=1.
  - When a pulse_10ms brings idle to HB_TICKS, a type-1 entry is written with the current count/epoch and idle returns to 0.
  - Any rise with ena=1 resets idle to 0, whether or not its entry was accepted.
  - If a rise and a heartbeat fall in the same cycle, only the trigger entry is written and idle goes to 0.
- ena=0:
  - Rises are ignored and no heartbeat is generated.
  - idle holds its value; the synchronizer keeps running.
  - Reads continue normally.
- Write when full:
  - The entry is dropped; overflow sets; drop_cnt increments, saturating at 255.
  - full is evaluated before any same-cycle read, so a read in that cycle does not make room for the write.
- Read:
  - rd_en with empty=0 -> rd_data updated and rd_valid=1 on the next cycle; otherwise rd_valid=0 and rd_data holds its value.
  - rd_en while empty is ignored.
  - A simultaneous write and read when 0 < level < DEPTH leaves level unchanged.
- Status timing: empty, full and level are registered and reflect the writes and reads of the previous edge. A write into an empty FIFO deasserts empty at the following edge.
- clr (priority over everything except rst), next edge:
  - FIFO flushed; epoch=0; idle=0; overflow=0; drop_cnt=0; rd_valid=0.
  - A rise or heartbeat in the same cycle is discarded without counting as a drop.
  - The synchronizer is not cleared.
- Reset mid-operation: all stored entries are lost, no partial entry is left, and rd_valid deasserts immediately.

Decomposition:
- Package sig_acq_pkg holds:
  - TS_W=48, EPOCH_W default, TYPE_TRIG=1'b0, TYPE_HB=1'b1;
  - field offsets TS_TYPE_BIT=47, TS_EPOCH_LSB=32.
- Sub-module ts_fifo: single-clock synchronous FIFO, parameterised on width and depth. Ports: wr_en/wr_data/rd_en/rd_data/rd_valid/empty/full/level/clr, with the same reset convention.
- Synchronizer, epoch, idle counter and drop accounting stay in timestamp_capture.

Test Plan:
- Reset/idle: hold rst low 5 cycles, release, no trig -> empty=1, level=0, rd_valid=0, overflow=0.
- Single capture:
  - count ramping, trig rises so s1 samples it at edge where count=0x100 -> one entry {0,0,0x00000102} (±1 count for the asynchronous sample).
  - rd_en -> rd_valid one cycle later with that data.
- Wrap boundary:
  - count=0xFFFFFFFE with trig timed so the capture lands in the pulse_full cycle -> entry epoch=1, count=0x00000000.
  - A later capture also shows epoch=1.
- Heartbeat: HB_TICKS=3, no trig, 3 pulse_10ms pulses -> exactly one type-1 entry. Trig and third tick in the same cycle -> only the trigger entry.
- Overflow: DEPTH=16, 20 rises with no reads -> full=1, level=16, overflow=1, drop_cnt=4. Then clr -> level=0, overflow=0, drop_cnt=0, epoch=0.
- Gating: ena=0 with 5 rises and 200 ticks -> no entries. rd_en while empty -> rd_valid stays 0.
